add_sub_accum: RTL and testbench

Streaming accumulator directly downstream of the 16-bit add/sub unit. It consumes the unit's 16-bit two's-complement results over a valid/ready stream and sums them into groups. Each group closes after `GRP_LEN` beats or on an early `in_last`. The block then emits one sign-extended group sum with its beat count and a sticky overflow flag on an output valid/ready stream.

---
 rtl/add_sub_pkg.sv | 18 +
 rtl/add_sub_accum.sv | 97 +++++++++
 tb/tb_add_sub_accum.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the add/sub datapath stages: default width, accumulator
// state encoding and a sign-based overflow detector.
package add_sub_pkg;

  localparam int unsigned DefaultDataW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  // Signed overflow of a + b: both operands share a sign that the sum does not.
  function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

endpackage

// File: rtl/add_sub_accum.sv
// Streaming group accumulator: sums sign-extended add/sub results into groups of up to
// GRP_LEN beats (or closed early by in_last) and emits sum, beat count and sticky overflow.
module add_sub_accum
  import add_sub_pkg::*;
#(
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned ACC_W   = 20,
  parameter int unsigned GRP_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [7:0]        out_count,
  output logic              out_ovf
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   data_ext;
  logic [ACC_W-1:0]   sum;
  logic [7:0]         cnt_inc;
  logic               accept;

  assign data_ext = {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};
  // acc/cnt/ovf are zero in StIdle, so the same adder path serves the first beat.
  assign sum      = acc_q + data_ext;
  assign cnt_inc  = cnt_q + 8'd1;
  assign in_ready = (state_q != StHold);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          acc_d = sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf(acc_q[ACC_W-1], data_ext[ACC_W-1], sum[ACC_W-1]);
          if (in_last || (cnt_inc == 8'(GRP_LEN))) begin
            state_d = StHold;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over any accept or output handshake in the same cycle.
    if (clear) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == StHold);
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_add_sub_accum.sv
// Directed scoreboard bench for add_sub_accum: a GRP_LEN=4 instance for most scenarios and
// a GRP_LEN=32 instance for the overflow group.
module tb_add_sub_accum;

  typedef struct packed {
    logic [19:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] in_data = '0;
  logic [1:0]  in_valid = '0;
  logic [1:0]  in_last = '0;
  logic [1:0]  out_ready = '0;
  logic [1:0]  in_ready;
  logic [1:0]  out_valid;
  logic [1:0]  out_ovf;
  logic [19:0] out_sum [2];
  logic [7:0]  out_count [2];

  res_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  add_sub_accum #(.DATA_W(16), .ACC_W(20), .GRP_LEN(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .in_data  (in_data),
    .in_last  (in_last[0]),
    .out_valid(out_valid[0]),
    .out_ready(out_ready[0]),
    .out_sum  (out_sum[0]),
    .out_count(out_count[0]),
    .out_ovf  (out_ovf[0])
  );

  add_sub_accum #(.DATA_W(16), .ACC_W(20), .GRP_LEN(32)) dut32 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .in_data  (in_data),
    .in_last  (in_last[1]),
    .out_valid(out_valid[1]),
    .out_ready(out_ready[1]),
    .out_sum  (out_sum[1]),
    .out_count(out_count[1]),
    .out_ovf  (out_ovf[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [19:0] sum, input logic [7:0] cnt, input logic ovf);
    res_t r;
    r.sum = sum;
    r.cnt = cnt;
    r.ovf = ovf;
    sb.push_back(r);
  endtask

  // Called at a negedge; presents one beat across the following posedge.
  task automatic beat(input int sel, input logic [15:0] d, input logic last);
    chk("in_ready_before_beat", 32'(in_ready[sel]), 32'd1);
    in_valid[sel] = 1'b1;
    in_data       = d;
    in_last[sel]  = last;
    @(negedge clk);
    in_valid[sel] = 1'b0;
    in_last[sel]  = 1'b0;
  endtask

  task automatic recv(input int sel);
    res_t e;
    int   waited;
    waited = 0;
    e = '0;
    while (!out_valid[sel] && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk("out_latency", 32'(waited), 32'd0);
    tests++;
    assert (sb.size() > 0) else begin
      fails++;
      $error("FAIL sb_underflow: observed empty expected entry");
    end
    if (sb.size() > 0) e = sb.pop_front();
    chk("out_valid_hold", 32'(out_valid[sel]), 32'd1);
    chk("in_ready_hold", 32'(in_ready[sel]), 32'd0);
    chk("out_sum", 32'(out_sum[sel]), 32'(e.sum));
    chk("out_count", 32'(out_count[sel]), 32'(e.cnt));
    chk("out_ovf", 32'(out_ovf[sel]), 32'(e.ovf));
    out_ready[sel] = 1'b1;
    @(negedge clk);
    out_ready[sel] = 1'b0;
    chk("out_valid_after_hs", 32'(out_valid[sel]), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready[sel]), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready[0]), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid[0]), 32'd0);
    chk({tag, "_out_sum"}, 32'(out_sum[0]), 32'd0);
    chk({tag, "_out_count"}, 32'(out_count[0]), 32'd0);
    chk({tag, "_out_ovf"}, 32'(out_ovf[0]), 32'd0);
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_in_ready32", 32'(in_ready[1]), 32'd1);
    rst_n = 1'b1;

    // Full group closed by GRP_LEN
    push_exp(20'h0000A, 8'd4, 1'b0);
    beat(0, 16'h0001, 1'b0);
    beat(0, 16'h0002, 1'b0);
    beat(0, 16'h0003, 1'b0);
    beat(0, 16'h0004, 1'b0);
    recv(0);

    // Early close via in_last
    push_exp(20'hF8010, 8'd2, 1'b0);
    beat(0, 16'h8000, 1'b0);
    beat(0, 16'h0010, 1'b1);
    recv(0);

    // Backpressure: offered beats must not be consumed while holding
    push_exp(20'h00004, 8'd4, 1'b0);
    for (int i = 0; i < 4; i++) beat(0, 16'h0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid[0] = 1'b1;
      in_data     = 16'h7777;
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
      chk("bp_out_sum", 32'(out_sum[0]), 32'h00004);
      chk("bp_out_count", 32'(out_count[0]), 32'd4);
    end
    in_valid[0] = 1'b0;
    recv(0);

    // Negative sum
    push_exp(20'hFFFFC, 8'd4, 1'b0);
    for (int i = 0; i < 4; i++) beat(0, 16'hFFFF, 1'b0);
    recv(0);

    // Overflow on the GRP_LEN=32 instance
    push_exp(20'h87FEF, 8'd17, 1'b1);
    for (int i = 0; i < 17; i++) beat(1, 16'h7FFF, (i == 16));
    recv(1);

    // Clear mid-group with a beat presented in the same cycle
    beat(0, 16'h0005, 1'b0);
    beat(0, 16'h0005, 1'b0);
    in_valid[0] = 1'b1;
    in_data     = 16'h0005;
    clear       = 1'b1;
    @(negedge clk);
    clear       = 1'b0;
    in_valid[0] = 1'b0;
    chk_idle("clear");
    push_exp(20'h00014, 8'd4, 1'b0);
    for (int i = 0; i < 4; i++) beat(0, 16'h0005, 1'b0);
    recv(0);

    // Reset mid-group
    beat(0, 16'h0005, 1'b0);
    beat(0, 16'h0005, 1'b0);
    in_valid[0] = 1'b1;
    in_data     = 16'h0005;
    rst_n       = 1'b0;
    @(negedge clk);
    rst_n       = 1'b1;
    in_valid[0] = 1'b0;
    chk_idle("midrst");
    push_exp(20'h00014, 8'd4, 1'b0);
    for (int i = 0; i < 4; i++) beat(0, 16'h0005, 1'b0);
    recv(0);

    // Clear discards a pending output
    beat(0, 16'h0009, 1'b1);
    chk("hold_before_clear", 32'(out_valid[0]), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_idle("hold_clear");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
